// File: rtl/ps2_key_sequencer_pkg.sv
// Shared types and constants for the PS/2 scan-code sequencer: prefix state,
// event record layout, drop-list bytes and the tracked game-key table.
package ps2_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXT_BRK
    } state_t;

    localparam logic [7:0] PFX_EXT      = 8'hE0;
    localparam logic [7:0] PFX_BRK      = 8'hF0;
    localparam logic [7:0] PFX_PAUSE    = 8'hE1;
    localparam logic [7:0] FAKE_SHIFT_L = 8'h12;
    localparam logic [7:0] FAKE_SHIFT_R = 8'h59;

    typedef struct packed {
        logic       rel;
        logic       ext;
        logic [7:0] code;
    } event_t;

    localparam int unsigned NUM_KEYS = 8;

    // {ext, code} of each tracked key; bit index in held follows this order
    localparam logic [8:0] KEY_UP    = 9'h175;
    localparam logic [8:0] KEY_DOWN  = 9'h172;
    localparam logic [8:0] KEY_LEFT  = 9'h16B;
    localparam logic [8:0] KEY_RIGHT = 9'h174;
    localparam logic [8:0] KEY_SPACE = 9'h029;
    localparam logic [8:0] KEY_ENTER = 9'h05A;
    localparam logic [8:0] KEY_ESC   = 9'h076;
    localparam logic [8:0] KEY_W     = 9'h01D;

    // Controller chatter and pause-sequence bytes that never form key events
    function automatic logic is_dropped(input logic [7:0] b);
        return b inside {PFX_PAUSE, 8'hAA, 8'hFA, 8'hEE, 8'hFC, 8'h00, 8'hFF};
    endfunction

    function automatic logic is_fake_shift(input logic [7:0] b);
        return (b == FAKE_SHIFT_L) || (b == FAKE_SHIFT_R);
    endfunction

    function automatic logic [NUM_KEYS-1:0] key_mask(input logic ext, input logic [7:0] code);
        logic [NUM_KEYS-1:0] m;
        m = '0;
        case ({ext, code})
            KEY_UP:    m[0] = 1'b1;
            KEY_DOWN:  m[1] = 1'b1;
            KEY_LEFT:  m[2] = 1'b1;
            KEY_RIGHT: m[3] = 1'b1;
            KEY_SPACE: m[4] = 1'b1;
            KEY_ENTER: m[5] = 1'b1;
            KEY_ESC:   m[6] = 1'b1;
            KEY_W:     m[7] = 1'b1;
            default:   ;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/ps2_key_sequencer_if.sv
// Byte-in / event-out handshake bundle of the scan-code sequencer.
interface ps2_key_sequencer_if;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic       evt_valid;
    logic       evt_ready;
    logic [7:0] evt_code;
    logic       evt_ext;
    logic       evt_release;

    modport master (
        output byte_valid, byte_data, evt_ready,
        input  evt_valid, evt_code, evt_ext, evt_release
    );

    modport slave (
        input  byte_valid, byte_data, evt_ready,
        output evt_valid, evt_code, evt_ext, evt_release
    );
endinterface

// File: rtl/ps2_key_sequencer_fifo.sv
// Show-ahead event FIFO; a push into a full FIFO succeeds only when a pop
// frees a slot in the same cycle. Head reads as zero while empty.
module ps2_event_fifo
    import ps2_seq_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic   clock,
    input  logic   resetn,
    input  logic   push,
    input  event_t din,
    input  logic   pop,
    output event_t dout,
    output logic   full,
    output logic   empty
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    event_t      mem [DEPTH];
    logic        do_pop;
    logic        do_push;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clock) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end
endmodule

// File: rtl/ps2_key_sequencer.sv
// PS/2 scan-code sequencer: prefix FSM, held-key bitmap, event FIFO.
// Optional: define PS2_REPEAT_FILTER_EN to suppress typematic repeat makes.
module ps2_key_sequencer
    import ps2_seq_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                 clock,
    input  logic                 resetn,
    ps2_key_sequencer_if.slave   bus,
    output logic [NUM_KEYS-1:0]  held,
    output logic                 overflow,
    input  logic                 clear_overflow
);
    localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    state_t              state;
    state_t              state_nxt;
    logic [TW-1:0]       cnt;
    logic                emit;
    event_t              evt;
    logic [NUM_KEYS-1:0] hit;
    logic                suppress;
    logic                push;
    logic                pop;
    logic                drop;
    logic                full;
    logic                empty;
    event_t              head;

`ifdef PS2_REPEAT_FILTER_EN
    logic [8:0]          last_make;
    logic                last_make_valid;
`endif

    always_comb begin
        state_nxt = state;
        emit      = 1'b0;
        evt       = '0;
        evt.code  = bus.byte_data;
        if (bus.byte_valid) begin
            case (state)
                ST_IDLE: begin
                    if (bus.byte_data == PFX_EXT)      state_nxt = ST_EXT;
                    else if (bus.byte_data == PFX_BRK) state_nxt = ST_BRK;
                    else if (!is_dropped(bus.byte_data)) emit = 1'b1;
                end
                ST_EXT: begin
                    if (bus.byte_data == PFX_BRK) begin
                        state_nxt = ST_EXT_BRK;
                    end else begin
                        state_nxt = ST_IDLE;
                        evt.ext   = 1'b1;
                        emit      = !is_fake_shift(bus.byte_data);
                    end
                end
                ST_BRK: begin
                    state_nxt = ST_IDLE;
                    evt.rel   = 1'b1;
                    emit      = 1'b1;
                end
                ST_EXT_BRK: begin
                    state_nxt = ST_IDLE;
                    evt.rel   = 1'b1;
                    evt.ext   = 1'b1;
                    emit      = 1'b1;
                end
                default: state_nxt = ST_IDLE;
            endcase
        end else if (state != ST_IDLE && cnt == TW'(TIMEOUT_CYCLES - 1)) begin
            state_nxt = ST_IDLE;
        end
    end

    assign hit = key_mask(evt.ext, evt.code);

`ifdef PS2_REPEAT_FILTER_EN
    // Tracked keys consult held; anything else consults the last emitted make
    assign suppress = emit & ~evt.rel &
                      ((|hit) ? (|(hit & held))
                              : (last_make_valid && last_make == {evt.ext, evt.code}));
`else
    assign suppress = 1'b0;
`endif

    assign push = emit & ~suppress;
    assign pop  = bus.evt_ready & ~empty;
    assign drop = push & full & ~pop;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state           <= ST_IDLE;
            cnt             <= '0;
            held            <= '0;
            overflow        <= 1'b0;
`ifdef PS2_REPEAT_FILTER_EN
            last_make       <= '0;
            last_make_valid <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            if (bus.byte_valid || state == ST_IDLE || state_nxt == ST_IDLE) cnt <= '0;
            else                                                            cnt <= cnt + TW'(1);

            if (emit && evt.rel) held <= held & ~hit;
            else if (emit)       held <= held | hit;

            if (drop)                overflow <= 1'b1;
            else if (clear_overflow) overflow <= 1'b0;
`ifdef PS2_REPEAT_FILTER_EN
            if (push && !evt.rel) begin
                last_make       <= {evt.ext, evt.code};
                last_make_valid <= 1'b1;
            end else if (emit && evt.rel && last_make == {evt.ext, evt.code}) begin
                last_make_valid <= 1'b0;
            end
`endif
        end
    end

    ps2_event_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock  (clock),
        .resetn (resetn),
        .push   (push),
        .din    (evt),
        .pop    (pop),
        .dout   (head),
        .full   (full),
        .empty  (empty)
    );

    assign bus.evt_valid   = ~empty;
    assign bus.evt_code    = head.code;
    assign bus.evt_ext     = head.ext;
    assign bus.evt_release = head.rel;
endmodule

// File: tb/tb_ps2_key_sequencer.sv
// Self-checking bench for ps2_key_sequencer: directed scenarios plus random
// byte streams against a prefix/queue reference model (PS2_REPEAT_FILTER_EN aware).
module tb_ps2_key_sequencer;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned TIMEOUT = 16;

    logic       clock;
    logic       resetn;
    logic       clear_overflow;
    logic [7:0] held;
    logic       overflow;
    int         total = 0;
    int         bad   = 0;

    ps2_key_sequencer_if bus ();

    ps2_key_sequencer #(
        .FIFO_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clock          (clock),
        .resetn         (resetn),
        .bus            (bus.slave),
        .held           (held),
        .overflow       (overflow),
        .clear_overflow (clear_overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model: pending prefix as flags, events as {rel, ext, code}
    logic [9:0] q [$];
    bit         m_active, m_ext, m_brk;
    int         m_idle;
    bit [7:0]   m_held;
    bit         m_ovf;
    bit         m_lm_valid;
    bit [8:0]   m_lm;
    bit [7:0]   tk_code [8] = '{8'h75, 8'h72, 8'h6B, 8'h74, 8'h29, 8'h5A, 8'h76, 8'h1D};
    bit         tk_ext  [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    bit [7:0]   junk    [9] = '{8'hE1, 8'hAA, 8'hFA, 8'hEE, 8'hFC, 8'h00, 8'hFF, 8'h12, 8'h59};

    function automatic int key_bit(bit ext, bit [7:0] code);
        for (int k = 0; k < 8; k++)
            if (tk_code[k] == code && tk_ext[k] == ext) return k;
        return -1;
    endfunction

    function automatic void model_reset();
        q.delete();
        m_active = 0; m_ext = 0; m_brk = 0; m_idle = 0;
        m_held = '0; m_ovf = 0; m_lm_valid = 0; m_lm = '0;
    endfunction

    function automatic void model_edge(bit v, bit [7:0] d, bit rdy, bit clr);
        bit emit = 0, rel = 0, ext = 0, keep, pop, dropped = 0;
        int kb;
        pop = rdy && (q.size() > 0);
        if (v) begin
            m_idle = 0;
            if (!m_active) begin
                if (d == 8'hE0)      begin m_active = 1; m_ext = 1; m_brk = 0; end
                else if (d == 8'hF0) begin m_active = 1; m_ext = 0; m_brk = 1; end
                else if (!(d inside {8'hE1, 8'hAA, 8'hFA, 8'hEE, 8'hFC, 8'h00, 8'hFF})) emit = 1;
            end else if (m_brk) begin
                emit = 1; rel = 1; ext = m_ext; m_active = 0;
            end else if (d == 8'hF0) begin
                m_brk = 1;
            end else begin
                m_active = 0;
                if (!(d inside {8'h12, 8'h59})) begin emit = 1; ext = 1; end
            end
        end else if (m_active) begin
            m_idle++;
            if (m_idle == TIMEOUT) begin m_active = 0; m_idle = 0; end
        end
        keep = emit;
        if (emit) begin
            kb = key_bit(ext, d);
            if (!rel) begin
`ifdef PS2_REPEAT_FILTER_EN
                if (kb >= 0 ? m_held[kb] : (m_lm_valid && m_lm == {ext, d})) keep = 0;
                if (keep) begin m_lm = {ext, d}; m_lm_valid = 1; end
`endif
                if (kb >= 0) m_held[kb] = 1;
            end else begin
                if (kb >= 0) m_held[kb] = 0;
`ifdef PS2_REPEAT_FILTER_EN
                if (m_lm == {ext, d}) m_lm_valid = 0;
`endif
            end
        end
        if (pop) void'(q.pop_front());
        if (keep) begin
            if (q.size() < DEPTH) q.push_back({rel, ext, d});
            else dropped = 1;
        end
        if (dropped) m_ovf = 1;
        else if (clr) m_ovf = 0;
    endfunction

    task automatic step(input bit v, input bit [7:0] d, input bit rdy, input bit clr);
        bus.byte_valid = v; bus.byte_data = d; bus.evt_ready = rdy; clear_overflow = clr;
        @(posedge clock);
        model_edge(v, d, rdy, clr);
        @(negedge clock);
    endtask

    task automatic do_reset();
        resetn = 0; bus.byte_valid = 1; bus.byte_data = 8'h1C; bus.evt_ready = 1; clear_overflow = 0;
        @(posedge clock);
        model_reset();
        @(negedge clock);
        resetn = 1; bus.byte_valid = 0; bus.evt_ready = 0;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if ({bus.evt_valid, bus.evt_release, bus.evt_ext, bus.evt_code} !== 11'h0) begin
            bad++; $display("FAIL reset_evt: got %h want 000", {bus.evt_valid, bus.evt_release, bus.evt_ext, bus.evt_code});
        end
        total++;
        if ({held, overflow} !== 9'h0) begin
            bad++; $display("FAIL reset_held_ovf: got %h want 000", {held, overflow});
        end
    endtask

    task automatic test_make_break();
        do_reset();
        step(1, 8'h1C, 0, 0);
        total++;
        if ({bus.evt_valid, bus.evt_release, bus.evt_ext, bus.evt_code} !== {1'b1, 10'h01C}) begin
            bad++; $display("FAIL make_1c: got %h want %h", {bus.evt_valid, bus.evt_release, bus.evt_ext, bus.evt_code}, {1'b1, 10'h01C});
        end
        step(1, 8'hF0, 1, 0);
        total++;
        if (bus.evt_valid !== 1'b0) begin bad++; $display("FAIL pop_after_make: got %b want 0", bus.evt_valid); end
        step(1, 8'h1C, 0, 0);
        total++;
        if ({bus.evt_valid, bus.evt_release, bus.evt_ext, bus.evt_code} !== {1'b1, 10'h21C}) begin
            bad++; $display("FAIL break_1c: got %h want %h", {bus.evt_valid, bus.evt_release, bus.evt_ext, bus.evt_code}, {1'b1, 10'h21C});
        end
        step(0, 8'h00, 1, 0);
    endtask

    task automatic test_extended_held();
        do_reset();
        step(1, 8'h75, 0, 0);
        total++;
        if (held !== 8'h00) begin bad++; $display("FAIL plain_75_not_tracked: got %h want 00", held); end
        step(1, 8'hE0, 1, 0);
        step(1, 8'h75, 0, 0);
        total++;
        if (held !== 8'h01) begin bad++; $display("FAIL held_up_set: got %h want 01", held); end
        total++;
        if ({bus.evt_valid, bus.evt_release, bus.evt_ext, bus.evt_code} !== {1'b1, 10'h175}) begin
            bad++; $display("FAIL make_e075: got %h want %h", {bus.evt_valid, bus.evt_release, bus.evt_ext, bus.evt_code}, {1'b1, 10'h175});
        end
        step(1, 8'hE0, 1, 0);
        step(1, 8'hF0, 0, 0);
        total++;
        if (held !== 8'h01) begin bad++; $display("FAIL held_during_prefix: got %h want 01", held); end
        step(1, 8'h75, 0, 0);
        total++;
        if (held !== 8'h00) begin bad++; $display("FAIL held_up_clear: got %h want 00", held); end
        total++;
        if ({bus.evt_valid, bus.evt_release, bus.evt_ext, bus.evt_code} !== {1'b1, 10'h375}) begin
            bad++; $display("FAIL break_e075: got %h want %h", {bus.evt_valid, bus.evt_release, bus.evt_ext, bus.evt_code}, {1'b1, 10'h375});
        end
    endtask

    task automatic test_repeat();
        logic [7:0] seq [5] = '{8'h29, 8'h29, 8'h29, 8'hF0, 8'h29};
        logic [9:0] got [$];
        int         want_n;
        do_reset();
        foreach (seq[i]) step(1, seq[i], 0, 0);
        for (int i = 0; i < 8; i++) begin
            if (bus.evt_valid) got.push_back({bus.evt_release, bus.evt_ext, bus.evt_code});
            step(0, 8'h00, 1, 0);
        end
`ifdef PS2_REPEAT_FILTER_EN
        want_n = 2;
`else
        want_n = 4;
`endif
        total++;
        if (got.size() != want_n) begin bad++; $display("FAIL repeat_count: got %0d want %0d", got.size(), want_n); end
        total++;
        if (got[0] !== 10'h029 || got[got.size()-1] !== 10'h229) begin
            bad++; $display("FAIL repeat_order: got first %h last %h want 029 229", got[0], got[got.size()-1]);
        end
        total++;
        if (held !== 8'h00) begin bad++; $display("FAIL repeat_held: got %h want 00", held); end
    endtask

    task automatic test_overflow();
        logic [7:0] codes [6] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B};
        logic [9:0] got [$];
        do_reset();
        foreach (codes[i]) step(1, codes[i], 0, 0);
        total++;
        if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_set: got %b want 1", overflow); end
        total++;
        if ({bus.evt_valid, bus.evt_code} !== 9'h11C) begin bad++; $display("FAIL ovf_head: got %h want 11c", {bus.evt_valid, bus.evt_code}); end
        step(0, 8'h00, 0, 1);
        total++;
        if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear: got %b want 0", overflow); end
        step(1, 8'h2C, 1, 0);
        total++;
        if ({overflow, bus.evt_code} !== 9'h032) begin bad++; $display("FAIL full_push_pop: got %h want 032", {overflow, bus.evt_code}); end
        step(1, 8'h2D, 0, 1);
        total++;
        if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_set_beats_clear: got %b want 1", overflow); end
        for (int i = 0; i < 8; i++) begin
            if (bus.evt_valid) got.push_back({bus.evt_release, bus.evt_ext, bus.evt_code});
            step(0, 8'h00, 1, 0);
        end
        total++;
        if (got.size() != 4 || got[3] !== 10'h02C) begin
            bad++; $display("FAIL ovf_drain: got n=%0d last=%h want n=4 last=02c", got.size(), got[got.size()-1]);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        step(1, 8'hE0, 0, 0);
        repeat (TIMEOUT - 1) step(0, 8'h00, 0, 0);
        step(1, 8'h75, 0, 0);
        total++;
        if ({bus.evt_valid, bus.evt_release, bus.evt_ext, bus.evt_code, held} !== {1'b1, 10'h175, 8'h01}) begin
            bad++; $display("FAIL prefix_kept_below_timeout: got %h want %h", {bus.evt_valid, bus.evt_release, bus.evt_ext, bus.evt_code, held}, {1'b1, 10'h175, 8'h01});
        end
        do_reset();
        step(1, 8'hE0, 0, 0);
        repeat (TIMEOUT) step(0, 8'h00, 0, 0);
        step(1, 8'h1C, 0, 0);
        total++;
        if ({bus.evt_valid, bus.evt_release, bus.evt_ext, bus.evt_code} !== {1'b1, 10'h01C}) begin
            bad++; $display("FAIL prefix_timeout: got %h want %h", {bus.evt_valid, bus.evt_release, bus.evt_ext, bus.evt_code}, {1'b1, 10'h01C});
        end
    endtask

    task automatic test_reset_midseq();
        do_reset();
        step(1, 8'hE0, 0, 0);
        step(1, 8'h29, 0, 0);
        step(1, 8'hF0, 0, 0);
        do_reset();
        total++;
        if ({bus.evt_valid, bus.evt_release, bus.evt_ext, bus.evt_code, held, overflow} !== 20'h0) begin
            bad++; $display("FAIL midseq_reset_outputs: got %h want 00000", {bus.evt_valid, bus.evt_release, bus.evt_ext, bus.evt_code, held, overflow});
        end
        step(1, 8'h1C, 0, 0);
        total++;
        if ({bus.evt_valid, bus.evt_release, bus.evt_ext, bus.evt_code} !== {1'b1, 10'h01C}) begin
            bad++; $display("FAIL midseq_prefix_discarded: got %h want %h", {bus.evt_valid, bus.evt_release, bus.evt_ext, bus.evt_code}, {1'b1, 10'h01C});
        end
    endtask

    task automatic test_random();
        int       quiet = 0;
        int       r;
        bit       v;
        bit [7:0] d;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 99);
            if (quiet == 0 && r < 2) quiet = $urandom_range(TIMEOUT - 2, TIMEOUT + 2);
            v = (quiet == 0) && ($urandom_range(0, 9) < 7);
            if (quiet > 0) quiet--;
            r = $urandom_range(0, 99);
            if (r < 15)      d = 8'hE0;
            else if (r < 32) d = 8'hF0;
            else if (r < 60) d = tk_code[$urandom_range(0, 7)];
            else if (r < 70) d = junk[$urandom_range(0, 8)];
            else             d = 8'($urandom);
            step(v, d, $urandom_range(0, 9) < 5, $urandom_range(0, 19) == 0);
            total++;
            if ({bus.evt_valid, held, overflow} !== {q.size() != 0, m_held, m_ovf}) begin
                bad++; $display("FAIL rand_status cyc %0d: got %h want %h", i, {bus.evt_valid, held, overflow}, {q.size() != 0, m_held, m_ovf});
            end
            if (q.size() != 0) begin
                total++;
                if ({bus.evt_release, bus.evt_ext, bus.evt_code} !== q[0]) begin
                    bad++; $display("FAIL rand_head cyc %0d: got %h want %h", i, {bus.evt_release, bus.evt_ext, bus.evt_code}, q[0]);
                end
            end
        end
    endtask

    initial begin
        resetn = 0; clear_overflow = 0;
        bus.byte_valid = 0; bus.byte_data = '0; bus.evt_ready = 0;
        model_reset();
        repeat (2) @(negedge clock);
        test_reset();
        test_make_break();
        test_extended_held();
        test_repeat();
        test_overflow();
        test_timeout();
        test_reset_midseq();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
